// File: rtl/regfile_param.sv
// +-----------------------------------------------------------------------+
// | regfile_param: 2R/1W register file, r0 hardwired to zero, write       |
// | bypass, tap output and a ready/valid full-array dump stream.           |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TAP_REG    = 29
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  output logic [DATA_WIDTH-1:0] tap_data,
  input  logic                  dump_start,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_busy
);

  localparam int                    DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TAP_IDX   = ADDR_WIDTH'(TAP_REG);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  dump_state_t           state;
  dump_state_t           state_next;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [DATA_WIDTH-1:0] next_data;

  // Register array; address 0 is never written so it stays at its reset value.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (ctrl_writeEnable && (ctrl_writeReg != '0)) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    if (ctrl_readRegA == '0) begin
      data_readRegA = '0;
    end else if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA)) begin
      data_readRegA = data_writeReg;
    end
  end

  always_comb begin
    data_readRegB = regs[ctrl_readRegB];
    if (ctrl_readRegB == '0) begin
      data_readRegB = '0;
    end else if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB)) begin
      data_readRegB = data_writeReg;
    end
  end

  // Tap reads stored contents only, so it lags a write by one cycle.
  generate
    if (TAP_REG == 0) begin : g_tap_zero
      assign tap_data = '0;
    end else begin : g_tap_reg
      assign tap_data = regs[TAP_IDX];
    end
  endgenerate

  // Dump fetch path: the next beat sees a same-edge write to its address.
  always_comb begin
    next_addr = dump_addr + ADDR_ONE;
    next_data = regs[next_addr];
    if (next_addr == '0) begin
      next_data = '0;
    end else if (ctrl_writeEnable && (ctrl_writeReg == next_addr)) begin
      next_data = data_writeReg;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    transfer   = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_next = SEND;
        end
      end
      SEND: begin
        transfer = dump_ready;
        if (dump_ready && (dump_addr == LAST_ADDR)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      dump_addr <= '0;
      dump_data <= '0;
    end else if ((state == IDLE) && dump_start) begin
      dump_addr <= '0;
      dump_data <= '0;
    end else if (transfer && (dump_addr != LAST_ADDR)) begin
      dump_addr <= next_addr;
      dump_data <= next_data;
    end
  end

  assign dump_valid = (state == SEND);
  assign dump_busy  = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param: default configuration plus
// a small 16-bit / 8-entry instance.
`default_nettype none

module tb_regfile_param;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr_a = '0;
  logic [4:0]  raddr_b = '0;
  logic [31:0] rd_a, rd_b, tap;
  logic        dump_start = 1'b0;
  logic        dump_ready = 1'b0;
  logic        dump_valid, dump_busy;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;

  logic        s_reset = 1'b1;
  logic        s_we = 1'b0;
  logic [2:0]  s_waddr = '0;
  logic [15:0] s_wdata = '0;
  logic [2:0]  s_raddr_a = '0;
  logic [2:0]  s_raddr_b = '0;
  logic [15:0] s_rd_a, s_rd_b, s_tap;
  logic        s_start = 1'b0;
  logic        s_ready = 1'b0;
  logic        s_valid, s_busy;
  logic [2:0]  s_addr;
  logic [15:0] s_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_param u_dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we),
    .ctrl_writeReg(waddr), .data_writeReg(wdata),
    .ctrl_readRegA(raddr_a), .ctrl_readRegB(raddr_b),
    .data_readRegA(rd_a), .data_readRegB(rd_b), .tap_data(tap),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy)
  );

  regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .TAP_REG(5)) u_small (
    .clock(clock), .ctrl_reset(s_reset), .ctrl_writeEnable(s_we),
    .ctrl_writeReg(s_waddr), .data_writeReg(s_wdata),
    .ctrl_readRegA(s_raddr_a), .ctrl_readRegB(s_raddr_b),
    .data_readRegA(s_rd_a), .data_readRegB(s_rd_b), .tap_data(s_tap),
    .dump_start(s_start), .dump_valid(s_valid), .dump_ready(s_ready),
    .dump_addr(s_addr), .dump_data(s_data), .dump_busy(s_busy)
  );

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clock); #1;
    we = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    ctrl_reset = 1'b1; we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0077; raddr_a = 5'd7;
    #1;
    checks++;
    if (rd_a !== 32'h0000_0077) begin
      errors++; $display("FAIL reset_bypass: got %h expected %h", rd_a, 32'h77);
    end
    @(negedge clock);
    we = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (rd_a !== 32'h0) begin
      errors++; $display("FAIL reset_read: got %h expected 0", rd_a);
    end
    checks++;
    if ({dump_valid, dump_busy, dump_addr, dump_data, tap} !== '0) begin
      errors++; $display("FAIL reset_outputs: got v=%b b=%b a=%h d=%h t=%h expected all 0",
                         dump_valid, dump_busy, dump_addr, dump_data, tap);
    end
    ctrl_reset = 1'b0;
  endtask

  task automatic test_write_read;
    write_reg(5'd5, 32'hDEAD_BEEF);
    raddr_a = 5'd5; raddr_b = 5'd0; #1;
    checks++;
    if (rd_a !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_r5: got %h expected deadbeef", rd_a);
    end
    checks++;
    if (rd_b !== 32'h0) begin
      errors++; $display("FAIL read_r0: got %h expected 0", rd_b);
    end
    write_reg(5'd0, 32'h0000_1234);
    raddr_a = 5'd0; #1;
    checks++;
    if (rd_a !== 32'h0) begin
      errors++; $display("FAIL write_r0_discard: got %h expected 0", rd_a);
    end
    write_reg(5'd31, 32'hCAFE_F00D);
    raddr_b = 5'd31; #1;
    checks++;
    if (rd_b !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL read_r31: got %h expected cafef00d", rd_b);
    end
  endtask

  task automatic test_bypass;
    @(negedge clock);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; raddr_a = 5'd7; #1;
    checks++;
    if (rd_a !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL bypass_a: got %h expected a5a5a5a5", rd_a);
    end
    checks++;
    if (tap !== 32'h0) begin
      errors++; $display("FAIL tap_untouched: got %h expected 0", tap);
    end
    @(negedge clock);
    waddr = 5'd29; wdata = 32'h1234_5678; #1;
    checks++;
    if (tap !== 32'h0) begin
      errors++; $display("FAIL tap_no_bypass: got %h expected 0", tap);
    end
    @(posedge clock); #1;
    we = 1'b0;
    checks++;
    if (tap !== 32'h1234_5678) begin
      errors++; $display("FAIL tap_update: got %h expected 12345678", tap);
    end
  endtask

  task automatic test_dump_full;
    int beat;
    for (int n = 1; n < 32; n++) write_reg(5'(n), 32'(n));
    @(negedge clock);
    dump_start = 1'b1; dump_ready = 1'b1;
    @(negedge clock); #1;
    dump_start = 1'b0;
    beat = 0;
    while (dump_valid && beat < 40) begin
      checks++;
      if (dump_addr !== 5'(beat) || dump_data !== 32'(beat)) begin
        errors++; $display("FAIL full_beat%0d: got %h/%h expected %h/%h",
                           beat, dump_addr, dump_data, 5'(beat), beat);
      end
      dump_start = (beat == 31);
      beat++;
      @(negedge clock); #1;
    end
    dump_start = 1'b0;
    checks++;
    if (beat !== 32) begin
      errors++; $display("FAIL full_beat_count: got %0d expected 32", beat);
    end
    checks++;
    if (dump_busy !== 1'b0 || dump_addr !== 5'd31 || dump_data !== 32'd31) begin
      errors++; $display("FAIL full_end: got b=%b a=%h d=%h expected 0/1f/1f",
                         dump_busy, dump_addr, dump_data);
    end
    @(negedge clock); #1;
    checks++;
    if (dump_valid !== 1'b0) begin
      errors++; $display("FAIL start_on_last_ignored: got %b expected 0", dump_valid);
    end
  endtask

  task automatic test_dump_stall;
    int beat;
    bit wrote3, stalled;
    logic [7:0]  lfsr;
    logic [4:0]  held_addr;
    logic [31:0] held_data, exp_data;
    @(negedge clock);
    dump_start = 1'b1; dump_ready = 1'b0;
    @(negedge clock); #1;
    dump_start = 1'b0;
    beat = 0; wrote3 = 1'b0; stalled = 1'b0; lfsr = 8'hA7;
    held_addr = '0; held_data = '0;
    for (int cyc = 0; cyc < 300 && dump_valid; cyc++) begin
      if (stalled) begin
        checks++;
        if (dump_addr !== held_addr || dump_data !== held_data) begin
          errors++; $display("FAIL stall_hold: got %h/%h expected %h/%h",
                             dump_addr, dump_data, held_addr, held_data);
        end
      end
      we = 1'b0;
      if (dump_addr == 5'd3 && !wrote3) begin
        dump_ready = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h0000_FFFF; wrote3 = 1'b1;
      end else if (dump_addr == 5'd5) begin
        dump_ready = 1'b1; we = 1'b1; waddr = 5'd6; wdata = 32'h0000_6666;
      end else begin
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        dump_ready = lfsr[0];
      end
      if (dump_ready) begin
        exp_data = (beat == 6) ? 32'h0000_6666 : 32'(beat);
        checks++;
        if (dump_addr !== 5'(beat) || dump_data !== exp_data) begin
          errors++; $display("FAIL stall_beat%0d: got %h/%h expected %h/%h",
                             beat, dump_addr, dump_data, 5'(beat), exp_data);
        end
        beat++;
      end
      stalled = !dump_ready; held_addr = dump_addr; held_data = dump_data;
      @(negedge clock); #1;
    end
    we = 1'b0;
    checks++;
    if (beat !== 32 || dump_valid !== 1'b0) begin
      errors++; $display("FAIL stall_beat_count: got %0d valid=%b expected 32 valid=0",
                         beat, dump_valid);
    end
  endtask

  task automatic test_reset_mid_dump;
    int cyc;
    @(negedge clock);
    dump_start = 1'b1; dump_ready = 1'b1;
    @(negedge clock); #1;
    dump_start = 1'b0;
    cyc = 0;
    while (dump_addr != 5'd10 && cyc < 40) begin
      @(negedge clock); #1;
      cyc++;
    end
    ctrl_reset = 1'b1; dump_start = 1'b1;
    we = 1'b1; waddr = 5'd9; wdata = 32'h9999_9999;
    @(negedge clock);
    ctrl_reset = 1'b0; dump_start = 1'b0; we = 1'b0;
    raddr_a = 5'd5; raddr_b = 5'd9; #1;
    checks++;
    if ({dump_valid, dump_busy, dump_addr, dump_data} !== '0) begin
      errors++; $display("FAIL abort_dump: got v=%b b=%b a=%h d=%h expected all 0",
                         dump_valid, dump_busy, dump_addr, dump_data);
    end
    checks++;
    if (rd_a !== 32'h0 || rd_b !== 32'h0 || tap !== 32'h0) begin
      errors++; $display("FAIL abort_reads: got %h %h %h expected 0 0 0", rd_a, rd_b, tap);
    end
    @(negedge clock);
    dump_start = 1'b1;
    @(negedge clock); #1;
    dump_start = 1'b0;
    checks++;
    if (dump_valid !== 1'b1 || dump_addr !== 5'd0) begin
      errors++; $display("FAIL restart: got v=%b a=%h expected 1/00", dump_valid, dump_addr);
    end
    @(negedge clock); #1;
    checks++;
    if (dump_addr !== 5'd1 || dump_data !== 32'h0) begin
      errors++; $display("FAIL restart_beat1: got %h/%h expected 01/0", dump_addr, dump_data);
    end
    cyc = 0;
    while (dump_valid && cyc < 40) begin
      @(negedge clock); #1;
      cyc++;
    end
    checks++;
    if (dump_busy !== 1'b0) begin
      errors++; $display("FAIL restart_done: got busy=%b expected 0", dump_busy);
    end
  endtask

  task automatic test_small;
    int beat;
    @(negedge clock);
    s_reset = 1'b0;
    for (int n = 1; n < 8; n++) begin
      @(negedge clock);
      s_we = 1'b1; s_waddr = 3'(n); s_wdata = 16'(n);
    end
    @(negedge clock); #1;
    s_we = 1'b0; s_raddr_a = 3'd5; s_raddr_b = 3'd7; #1;
    checks++;
    if (s_tap !== 16'd5 || s_rd_a !== 16'd5 || s_rd_b !== 16'd7) begin
      errors++; $display("FAIL small_load: got tap=%h a=%h b=%h expected 5/5/7",
                         s_tap, s_rd_a, s_rd_b);
    end
    s_start = 1'b1; s_ready = 1'b1;
    @(negedge clock); #1;
    s_start = 1'b0;
    beat = 0;
    while (s_valid && beat < 12) begin
      checks++;
      if (s_addr !== 3'(beat) || s_data !== 16'(beat)) begin
        errors++; $display("FAIL small_beat%0d: got %h/%h expected %h/%h",
                           beat, s_addr, s_data, 3'(beat), beat);
      end
      beat++;
      @(negedge clock); #1;
    end
    checks++;
    if (beat !== 8 || s_busy !== 1'b0) begin
      errors++; $display("FAIL small_beat_count: got %0d busy=%b expected 8 busy=0", beat, s_busy);
    end
    s_we = 1'b1; s_waddr = 3'd5; s_wdata = 16'hABCD; #1;
    checks++;
    if (s_tap !== 16'd5) begin
      errors++; $display("FAIL small_tap_before: got %h expected 0005", s_tap);
    end
    @(posedge clock); #1;
    s_we = 1'b0;
    checks++;
    if (s_tap !== 16'hABCD) begin
      errors++; $display("FAIL small_tap_after: got %h expected abcd", s_tap);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_bypass;
    test_dump_full;
    test_dump_stall;
    test_reset_mid_dump;
    test_small;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
